uart_tx_stream: RTL and testbench

Downstream consumer of the RAM/fread loader's byte stream. Accepts bytes on the valid/ack handshake the loader drives (valid held until ack seen; producer drops valid the cycle after ack), buffers them in a small FIFO, and serialises them LSB-first on a UART TX pin. Frame format: 1 start bit, 8 data bits, optional parity, 1 or 2 stop bits. Sits between the loader and the FPGA UART pin, so the loader never stalls on bit timing except when the FIFO is full.

---
 rtl/uart_tx_stream_pkg.sv | 27 ++
 rtl/uart_tx_stream_if.sv | 9 +
 rtl/uart_tx_stream_sync_fifo.sv | 55 +++++
 rtl/uart_tx_stream.sv | 154 +++++++++++++++
 tb/tb_uart_tx_stream.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_stream_pkg.sv
// Shared types and helpers for the UART byte-stream transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Line level for the parity slot; PAR_NONE yields the idle level.
  function automatic logic parity_bit(input logic [7:0] d, input int unsigned mode);
    logic p;
    p = 1'b1;
    if (mode == PAR_EVEN)
      p = ^d;
    else if (mode == PAR_ODD)
      p = ~(^d);
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_stream_if.sv
// Byte-stream handshake between the loader (master) and the UART transmitter (slave).
interface uart_tx_stream_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ack;

  modport master (output in_valid, output in_data, input in_ack);
  modport slave  (input in_valid, input in_data, output in_ack);
endinterface

// File: rtl/uart_tx_stream_sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + ONE;
      if (do_pop)
        rd_ptr <= rd_ptr + ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_stream.sv
// Buffers handshaked bytes in a FIFO and serialises them LSB-first on a UART TX line.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int unsigned DIV       = 104,
  parameter int unsigned FIFO_AW   = 4,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_stream_if.slave     up,
  output logic                tx,
  output logic                busy,
  output logic [FIFO_AW:0]    fifo_level
);

  localparam logic [15:0] RELOAD    = 16'(DIV - 1);
  localparam logic        STOP_LAST = (STOP_BITS == 2);

  state_t      state, state_n;
  logic [15:0] baud, baud_n;
  logic [2:0]  bit_cnt, bit_n;
  logic        stop_cnt, stop_n;
  logic [7:0]  sh, sh_n;
  logic        par, par_n;
  logic        tx_n;
  logic        busy_d;
  logic        bit_done;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;

  assign up.in_ack = up.in_valid & ~fifo_full & ~rst;
  assign push      = up.in_ack;

  sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (up.in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // tx is registered from the current state, so the line trails the FSM by one cycle.
  always_comb begin
    state_n  = state;
    baud_n   = baud;
    bit_n    = bit_cnt;
    stop_n   = stop_cnt;
    sh_n     = sh;
    par_n    = par;
    pop      = 1'b0;
    tx_n     = 1'b1;
    bit_done = (baud == '0);
    if (!bit_done)
      baud_n = baud - 16'd1;

    case (state)
      ST_IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_n    = fifo_dout;
          par_n   = parity_bit(fifo_dout, PARITY);
          baud_n  = RELOAD;
          state_n = ST_START;
        end
      end
      ST_START: begin
        tx_n = 1'b0;
        if (bit_done) begin
          baud_n  = RELOAD;
          bit_n   = '0;
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_n = sh[0];
        if (bit_done) begin
          sh_n   = {1'b0, sh[7:1]};
          baud_n = RELOAD;
          if (bit_cnt == 3'd7) begin
            stop_n  = 1'b0;
            state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        tx_n = par;
        if (bit_done) begin
          baud_n  = RELOAD;
          stop_n  = 1'b0;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        tx_n = 1'b1;
        if (bit_done) begin
          if (stop_cnt != STOP_LAST) begin
            stop_n = 1'b1;
            baud_n = RELOAD;
          end else if (!fifo_empty) begin
            // Back-to-back: pop on the final stop cycle so the next start bit follows directly.
            pop     = 1'b1;
            sh_n    = fifo_dout;
            par_n   = parity_bit(fifo_dout, PARITY);
            baud_n  = RELOAD;
            state_n = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    busy_d = push | ~fifo_empty | (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      sh       <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bit_cnt  <= bit_n;
      stop_cnt <= stop_n;
      sh       <= sh_n;
      par      <= par_n;
      tx       <= tx_n;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Self-checking bench for uart_tx_stream: three configurations, waveform compared against a frame model.
module tb_uart_tx_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] valid;
  logic [7:0] data [3];
  logic [2:0] ack;
  logic [2:0] tx;
  logic [2:0] busy;
  logic [4:0] lvl [3];
  logic [4:0] lvl0;
  logic [2:0] lvl1;
  logic [2:0] lvl2;

  uart_tx_stream_if if0 ();
  uart_tx_stream_if if1 ();
  uart_tx_stream_if if2 ();

  assign if0.in_valid = valid[0];
  assign if1.in_valid = valid[1];
  assign if2.in_valid = valid[2];
  assign if0.in_data  = data[0];
  assign if1.in_data  = data[1];
  assign if2.in_data  = data[2];
  assign ack[0] = if0.in_ack;
  assign ack[1] = if1.in_ack;
  assign ack[2] = if2.in_ack;
  assign lvl[0] = lvl0;
  assign lvl[1] = {2'b00, lvl1};
  assign lvl[2] = {2'b00, lvl2};

  uart_tx_stream #(.DIV(4), .FIFO_AW(4), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .up(if0), .tx(tx[0]), .busy(busy[0]), .fifo_level(lvl0));
  uart_tx_stream #(.DIV(4), .FIFO_AW(2), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .up(if1), .tx(tx[1]), .busy(busy[1]), .fifo_level(lvl1));
  uart_tx_stream #(.DIV(4), .FIFO_AW(2), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .up(if2), .tx(tx[2]), .busy(busy[2]), .fifo_level(lvl2));

  bit q0[$];
  bit q1[$];
  bit q2[$];
  always @(negedge clk) begin
    q0.push_back(tx[0]);
    q1.push_back(tx[1]);
    q2.push_back(tx[2]);
  end

  int nasrt = 0;
  int nfail = 0;
  int stalls = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int now();
    return q0.size() - 1;
  endfunction

  // Expected line level j cycles into a frame carrying byte b.
  function automatic bit model_bit(input logic [7:0] b, input int j, input int div, input int par);
    int k;
    k = j / div;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (par != 0 && k == 9) return (par == 1) ? ^b : ~(^b);
    return 1'b1;
  endfunction

  task automatic scan(input bit log[$], input int lo, input int hi, input int div, input int par,
                      input int stops, input logic [7:0] exp[$],
                      output int nfr, output int nbad, output int gaps, output int first);
    int flen;
    int i;
    int last_end;
    flen = (9 + ((par != 0) ? 1 : 0) + stops) * div;
    i = lo;
    last_end = -1;
    nfr = 0; nbad = 0; gaps = 0; first = -1;
    while (i < hi) begin
      if (log[i] == 1'b0) begin
        if (first < 0) first = i;
        else gaps += i - last_end;
        for (int j = 0; j < flen; j++)
          if (i + j < hi)
            if (nfr >= exp.size() || log[i+j] != model_bit(exp[nfr], j, div, par)) nbad++;
        last_end = i + flen;
        i += flen;
        nfr++;
      end else begin
        i++;
      end
    end
  endtask

  task automatic push_byte(input int d, input logic [7:0] b, output int ack_idx);
    logic [4:0] full_lvl;
    full_lvl = (d == 0) ? 5'd16 : 5'd4;
    tick();
    valid[d] = 1'b1;
    data[d]  = b;
    ack_idx  = -1;
    for (int c = 0; c < 5000; c++) begin
      #1;
      if (lvl[d] == full_lvl) begin
        stalls++;
        chk("ack_when_full", {31'd0, ack[d]}, 32'd0);
      end
      if (ack[d]) begin
        ack_idx = now();
        break;
      end
      tick();
    end
    chk("ack_bound", {31'd0, ack_idx >= 0}, 32'd1);
    tick();
    valid[d] = 1'b0;
    data[d]  = 8'($urandom);
  endtask

  task automatic wait_idle(input int d, input int budget, output int idx);
    idx = -1;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (busy[d] == 1'b0) begin
        idx = now();
        break;
      end
    end
    chk("idle_bound", {31'd0, idx >= 0}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e[$];
    logic [7:0] ra, rb;
    int a, a0, a1, a2, b1, b2, idx, f, m, cnt;
    int nfr, nbad, gaps, first;

    rst = 1'b1;
    valid = '0;
    for (int d = 0; d < 3; d++) data[d] = 8'h00;
    tick();
    tick();
    valid[0] = 1'b1;
    data[0]  = 8'h3C;
    #1;
    chk("reset_ack", {31'd0, ack[0]}, 32'd0);
    for (int d = 0; d < 3; d++) begin
      chk("reset_tx",   {31'd0, tx[d]},   32'd1);
      chk("reset_busy", {31'd0, busy[d]}, 32'd0);
      chk("reset_lvl",  {27'd0, lvl[d]},  32'd0);
    end
    valid[0] = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Single byte, latency, bit timing, busy envelope
    push_byte(0, 8'hA5, a);
    chk("t1_busy_rise", {31'd0, busy[0]}, 32'd1);
    chk("t1_level", {27'd0, lvl[0]}, 32'd1);
    wait_idle(0, 200, idx);
    chk("t1_busy_fall", idx, a + 43);
    tick(); tick();
    f = -1;
    for (int i = a; i < q0.size(); i++) if (q0[i] == 1'b0) begin f = i; break; end
    chk("t1_tx_fall", f, a + 3);
    e = '{8'hA5};
    scan(q0, a, q0.size(), 4, 0, 1, e, nfr, nbad, gaps, first);
    chk("t1_frames", nfr, 1);
    chk("t1_bad_samples", nbad, 0);

    // Loader-style burst 0x00..0x1F through a 16-deep FIFO
    e = {};
    stalls = 0;
    a0 = -1;
    for (int b = 0; b < 32; b++) begin
      push_byte(0, 8'(b), a);
      if (b == 0) a0 = a;
      e.push_back(8'(b));
    end
    chk("t2_stalled_full", {31'd0, stalls > 0}, 32'd1);
    wait_idle(0, 3000, idx);
    scan(q0, a0, q0.size(), 4, 0, 1, e, nfr, nbad, gaps, first);
    chk("t2_frames", nfr, 32);
    chk("t2_bad_samples", nbad, 0);
    chk("t2_gaps", gaps, 0);
    chk("t2_first_start", first, a0 + 3);
    chk("t2_busy_fall", idx, first + 1280);

    // Parity: even on dut1, odd on dut2
    push_byte(1, 8'h07, a1);
    push_byte(2, 8'h07, a2);
    wait_idle(1, 300, idx);
    wait_idle(2, 300, idx);
    tick();
    chk("t3_even_parity", {31'd0, q1[a1+3+36]}, 32'd1);
    chk("t3_odd_parity",  {31'd0, q2[a2+3+36]}, 32'd0);
    e = '{8'h07};
    scan(q1, a1, q1.size(), 4, 1, 2, e, nfr, nbad, gaps, first);
    chk("t3_even_frame", nbad, 0);
    scan(q2, a2, q2.size(), 4, 2, 1, e, nfr, nbad, gaps, first);
    chk("t3_odd_frame", nbad, 0);
    chk("t3_odd_start", first, a2 + 3);

    // Two stop bits, back-to-back
    push_byte(1, 8'h55, b1);
    push_byte(1, 8'hFF, b2);
    wait_idle(1, 400, idx);
    tick();
    cnt = 0;
    for (int i = b1 + 3 + 40; i < b1 + 3 + 48; i++) if (q1[i]) cnt++;
    chk("t4_stop_high", cnt, 8);
    chk("t4_next_start", {31'd0, q1[b1+3+48]}, 32'd0);
    e = '{8'h55, 8'hFF};
    scan(q1, b1, q1.size(), 4, 1, 2, e, nfr, nbad, gaps, first);
    chk("t4_frames", nfr, 2);
    chk("t4_bad_samples", nbad, 0);
    chk("t4_gaps", gaps, 0);

    // Random bytes with random gaps on the odd-parity instance
    e = {};
    a0 = -1;
    for (int n = 0; n < 10; n++) begin
      ra = 8'($urandom_range(0, 255));
      push_byte(2, ra, a);
      if (n == 0) a0 = a;
      e.push_back(ra);
      repeat ($urandom_range(0, 60)) tick();
    end
    wait_idle(2, 2000, idx);
    tick();
    scan(q2, a0, q2.size(), 4, 2, 1, e, nfr, nbad, gaps, first);
    chk("rand_frames", nfr, 10);
    chk("rand_bad_samples", nbad, 0);

    // Reset during data bit 3 with bytes queued
    a0 = -1;
    for (int n = 0; n < 3; n++) begin
      push_byte(0, 8'($urandom_range(0, 255)), a);
      if (n == 0) a0 = a;
    end
    f = -1;
    for (int c = 0; c < 200 && f < 0; c++) begin
      for (int i = a0; i < q0.size(); i++) if (q0[i] == 1'b0) begin f = i; break; end
      if (f < 0) tick();
    end
    chk("t5_frame_seen", {31'd0, f >= 0}, 32'd1);
    for (int c = 0; c < 200 && now() < f + 17; c++) tick();
    rst = 1'b1;
    valid[0] = 1'b1;
    data[0]  = 8'($urandom);
    #1;
    chk("t5_ack_in_rst", {31'd0, ack[0]}, 32'd0);
    tick();
    chk("t5_tx", {31'd0, tx[0]}, 32'd1);
    chk("t5_busy", {31'd0, busy[0]}, 32'd0);
    chk("t5_lvl", {27'd0, lvl[0]}, 32'd0);
    chk("t5_ack_still_rst", {31'd0, ack[0]}, 32'd0);
    rst = 1'b0;
    valid[0] = 1'b0;
    m = now();
    repeat (150) tick();
    cnt = 0;
    for (int i = m; i < q0.size(); i++) if (q0[i] == 1'b0) cnt++;
    chk("t5_no_frames", cnt, 0);
    chk("t5_busy_after", {31'd0, busy[0]}, 32'd0);

    // Push on the same edge the engine pops
    ra = 8'($urandom_range(0, 255));
    rb = 8'($urandom_range(0, 255));
    tick();
    valid[0] = 1'b1;
    data[0]  = ra;
    #1;
    chk("t6_ack_a", {31'd0, ack[0]}, 32'd1);
    a = now();
    tick();
    data[0] = rb;
    #1;
    chk("t6_ack_b", {31'd0, ack[0]}, 32'd1);
    chk("t6_lvl_before", {27'd0, lvl[0]}, 32'd1);
    tick();
    valid[0] = 1'b0;
    chk("t6_lvl_after", {27'd0, lvl[0]}, 32'd1);
    wait_idle(0, 300, idx);
    tick();
    e = '{ra, rb};
    scan(q0, a, q0.size(), 4, 0, 1, e, nfr, nbad, gaps, first);
    chk("t6_frames", nfr, 2);
    chk("t6_bad_samples", nbad, 0);
    chk("t6_gaps", gaps, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end

endmodule
